// File: rtl/ex_mem_lsu_if.sv
// Load/store unit connection bundle: EX-stage request, data bus and Mem-stage result.
// The slave modport is the LSU view; the master modport is the surrounding pipeline/bus view.
interface ex_mem_lsu_if;
    // EX stage request
    logic        ex_valid_i;
    logic [2:0]  ex_op_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_sdata_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_wreg_i;
    logic        flush_i;
    // Data bus
    logic        dreq_o;
    logic        dwe_o;
    logic [3:0]  dbe_o;
    logic [31:0] daddr_o;
    logic [31:0] dwdata_o;
    logic [31:0] drdata_i;
    logic        dack_i;
    // Pipeline control and Mem stage result
    logic        stall_req_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        mem_write_o;
    logic        excp_o;
    logic [1:0]  excp_code_o;

    modport slave (
        input  ex_valid_i, ex_op_i, ex_addr_i, ex_sdata_i, ex_waddr_i, ex_wdata_i, ex_wreg_i,
        input  flush_i, drdata_i, dack_i,
        output dreq_o, dwe_o, dbe_o, daddr_o, dwdata_o,
        output stall_req_o, waddr_o, wdata_o, mem_write_o, excp_o, excp_code_o
    );

    modport master (
        output ex_valid_i, ex_op_i, ex_addr_i, ex_sdata_i, ex_waddr_i, ex_wdata_i, ex_wreg_i,
        output flush_i, drdata_i, dack_i,
        input  dreq_o, dwe_o, dbe_o, daddr_o, dwdata_o,
        input  stall_req_o, waddr_o, wdata_o, mem_write_o, excp_o, excp_code_o
    );
endinterface

// File: rtl/ex_mem_lsu.sv
// EX/MEM load/store unit: passes ALU results through, runs one data bus transfer per memory op
// (stalling EX while busy), extracts/extends load data, flags misalignment and bus timeouts.
module ex_mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    ex_mem_lsu_if.slave bus
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [2:0] OpLb  = 3'd1;
    localparam logic [2:0] OpLbu = 3'd2;
    localparam logic [2:0] OpLw  = 3'd3;
    localparam logic [2:0] OpSb  = 3'd4;
    localparam logic [2:0] OpSw  = 3'd5;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    localparam logic [1:0] CodeMisalign = 2'b01;
    localparam logic [1:0] CodeTimeout  = 2'b10;

    state_e      r_state, w_state_d;

    // Instruction held for the duration of the bus transfer
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [4:0]  r_waddr;
    logic        r_wreg;
    logic        r_kill, w_kill_d;
    logic [7:0]  r_cnt, w_cnt_d;

    // Registered Mem-stage result
    logic [4:0]  r_out_waddr, w_out_waddr_d;
    logic [31:0] r_out_wdata, w_out_wdata_d;
    logic        r_out_we, w_out_we_d;
    logic        r_excp, w_excp_d;
    logic [1:0]  r_excp_code, w_excp_code_d;

    logic        w_latch;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_killed;
    logic        w_is_load_q;
    logic        w_busy;
    logic [7:0]  w_byte;
    logic [31:0] w_load;

    assign w_is_mem     = (bus.ex_op_i >= OpLb) && (bus.ex_op_i <= OpSw);
    assign w_misaligned = ((bus.ex_op_i == OpLw) || (bus.ex_op_i == OpSw))
                          && (bus.ex_addr_i[1:0] != 2'b00);
    assign w_is_load_q  = (r_op == OpLb) || (r_op == OpLbu) || (r_op == OpLw);
    // A flush in the completing cycle kills the result as well
    assign w_killed     = r_kill | bus.flush_i;
    assign w_busy       = (r_state == StBusy);

    // Select the addressed byte lane (little-endian) and extend it for the held load
    always_comb begin
        w_byte = bus.drdata_i[7:0];
        unique case (r_addr[1:0])
            2'd0: w_byte = bus.drdata_i[7:0];
            2'd1: w_byte = bus.drdata_i[15:8];
            2'd2: w_byte = bus.drdata_i[23:16];
            2'd3: w_byte = bus.drdata_i[31:24];
        endcase
        case (r_op)
            OpLb:    w_load = {{24{w_byte[7]}}, w_byte};
            OpLbu:   w_load = {24'h0, w_byte};
            default: w_load = bus.drdata_i;
        endcase
    end

    // Next state, wait counter, kill flag and Mem-stage result
    always_comb begin
        w_state_d     = r_state;
        w_latch       = 1'b0;
        w_cnt_d       = r_cnt;
        w_kill_d      = r_kill;
        w_out_waddr_d = 5'd0;
        w_out_wdata_d = 32'd0;
        w_out_we_d    = 1'b0;
        w_excp_d      = 1'b0;
        w_excp_code_d = 2'b00;
        unique case (r_state)
            StIdle: begin
                if (bus.ex_valid_i && !bus.flush_i) begin
                    if (!w_is_mem) begin
                        w_out_waddr_d = bus.ex_waddr_i;
                        w_out_wdata_d = bus.ex_wdata_i;
                        w_out_we_d    = bus.ex_wreg_i;
                    end else if (w_misaligned) begin
                        w_excp_d      = 1'b1;
                        w_excp_code_d = CodeMisalign;
                    end else begin
                        w_latch   = 1'b1;
                        w_state_d = StBusy;
                        w_cnt_d   = 8'd0;
                        w_kill_d  = 1'b0;
                    end
                end
            end
            StBusy: begin
                if (bus.dack_i) begin
                    // Ack wins even in the timeout cycle
                    w_state_d = StIdle;
                    if (!w_killed && w_is_load_q) begin
                        w_out_waddr_d = r_waddr;
                        w_out_wdata_d = w_load;
                        w_out_we_d    = r_wreg;
                    end
                end else if (r_cnt == CntLast) begin
                    w_state_d = StIdle;
                    if (!w_killed) begin
                        w_excp_d      = 1'b1;
                        w_excp_code_d = CodeTimeout;
                    end
                end else begin
                    w_cnt_d  = r_cnt + 8'd1;
                    w_kill_d = w_killed;
                end
            end
        endcase
    end

    // State, counter, kill flag and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= 8'd0;
            r_kill      <= 1'b0;
            r_out_waddr <= 5'd0;
            r_out_wdata <= 32'd0;
            r_out_we    <= 1'b0;
            r_excp      <= 1'b0;
            r_excp_code <= 2'b00;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_kill      <= w_kill_d;
            r_out_waddr <= w_out_waddr_d;
            r_out_wdata <= w_out_wdata_d;
            r_out_we    <= w_out_we_d;
            r_excp      <= w_excp_d;
            r_excp_code <= w_excp_code_d;
        end
    end

    // Capture the memory instruction on BUSY entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= 3'd0;
            r_addr  <= 32'd0;
            r_sdata <= 32'd0;
            r_waddr <= 5'd0;
            r_wreg  <= 1'b0;
        end else if (w_latch) begin
            r_op    <= bus.ex_op_i;
            r_addr  <= bus.ex_addr_i;
            r_sdata <= bus.ex_sdata_i;
            r_waddr <= bus.ex_waddr_i;
            r_wreg  <= bus.ex_wreg_i;
        end
    end

    // Bus drive from the held instruction; everything is quiet while idle
    always_comb begin
        bus.dreq_o   = w_busy;
        bus.dwe_o    = 1'b0;
        bus.dbe_o    = 4'b0000;
        bus.daddr_o  = 32'd0;
        bus.dwdata_o = 32'd0;
        if (w_busy) begin
            bus.daddr_o = {r_addr[31:2], 2'b00};
            bus.dbe_o   = 4'b1111;
            if (r_op == OpSb) begin
                bus.dwe_o    = 1'b1;
                bus.dbe_o    = 4'b0001 << r_addr[1:0];
                bus.dwdata_o = {4{r_sdata[7:0]}};
            end else if (r_op == OpSw) begin
                bus.dwe_o    = 1'b1;
                bus.dwdata_o = r_sdata;
            end
        end
    end

    assign bus.stall_req_o = w_busy;
    assign bus.waddr_o     = r_out_waddr;
    assign bus.wdata_o     = r_out_wdata;
    assign bus.mem_write_o = r_out_we;
    assign bus.excp_o      = r_excp;
    assign bus.excp_code_o = r_excp_code;

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Testbench for ex_mem_lsu: vector table plus directed multi-cycle sequences, with a result
// scoreboard checked whenever the Mem-stage outputs carry anything other than a bubble.
module tb_ex_mem_lsu;

    localparam int unsigned TO = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mem_lsu_if u_if ();

    ex_mem_lsu #(.TIMEOUT(TO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wreg;
        logic [31:0] rdata;
        int          busy;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        dwe;
        logic [4:0]  o_waddr;
        logic [31:0] o_wdata;
        logic        o_we;
        logic [1:0]  o_code;
    } vec_t;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] s, input logic [4:0] wa, input logic [31:0] wd,
                            input logic we);
        u_if.ex_valid_i = v;
        u_if.ex_op_i    = op;
        u_if.ex_addr_i  = a;
        u_if.ex_sdata_i = s;
        u_if.ex_waddr_i = wa;
        u_if.ex_wdata_i = wd;
        u_if.ex_wreg_i  = we;
    endtask

    task automatic push(input logic [4:0] wa, input logic [31:0] wd, input logic we,
                        input logic [1:0] code);
        exp_t e;
        e.waddr = wa;
        e.wdata = wd;
        e.we    = we;
        e.code  = code;
        sb.push_back(e);
    endtask

    // Count BUSY cycles until stall drops, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (u_if.stall_req_o && n < 400) begin
            n++;
            tick();
        end
    endtask

    // Any non-bubble result must match the oldest expectation
    always @(negedge clk) begin
        if (mon_en && (u_if.excp_o || u_if.mem_write_o || u_if.waddr_o != 5'd0
                       || u_if.wdata_o != 32'd0)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", {u_if.excp_o, u_if.mem_write_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_waddr", 32'(u_if.waddr_o), 32'(e.waddr));
                check("sb_wdata", u_if.wdata_o, e.wdata);
                check("sb_mem_write", 32'(u_if.mem_write_o), 32'(e.we));
                check("sb_excp", 32'(u_if.excp_o), 32'(e.code != 2'b00));
                if (e.code != 2'b00) check("sb_excp_code", 32'(u_if.excp_code_o), 32'(e.code));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        drive_ex(1'b1, v.op, v.addr, v.sdata, v.waddr, v.wdata, v.wreg);
        if (v.o_waddr != 0 || v.o_wdata != 0 || v.o_we || v.o_code != 0)
            push(v.o_waddr, v.o_wdata, v.o_we, v.o_code);
        @(negedge clk);
        check("accept_stall", 32'(u_if.stall_req_o), 32'd0);
        check("accept_dreq", 32'(u_if.dreq_o), 32'd0);
        tick();
        drive_ex(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        for (int c = 1; c <= v.busy; c++) begin
            if (c == v.busy) begin
                u_if.dack_i   = 1'b1;
                u_if.drdata_i = v.rdata;
            end
            @(negedge clk);
            check("busy_stall", 32'(u_if.stall_req_o), 32'd1);
            check("busy_dreq", 32'(u_if.dreq_o), 32'd1);
            check("busy_daddr", u_if.daddr_o, v.daddr);
            check("busy_dbe", 32'(u_if.dbe_o), 32'(v.dbe));
            check("busy_dwe", 32'(u_if.dwe_o), 32'(v.dwe));
            if (v.dwe) check("busy_dwdata", u_if.dwdata_o, v.dwdata);
            tick();
            u_if.dack_i   = 1'b0;
            u_if.drdata_i = 32'h0BAD_F00D;
        end
        @(negedge clk);
        check("done_stall", 32'(u_if.stall_req_o), 32'd0);
        check("done_dreq", 32'(u_if.dreq_o), 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //             op    addr          sdata         wa     wdata         we    rdata       busy dbe   daddr          dwdata        dwe   o_wa   o_wdata       o_we  o_code
        vecs[0]  = '{3'd0, 32'h0000_0000, 32'h0,        5'd5,  32'h0000_1234, 1'b1, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b0, 5'd5,  32'h0000_1234, 1'b1, 2'd0};
        vecs[1]  = '{3'd1, 32'h0000_0103, 32'h0,        5'd7,  32'h0000_DEAD, 1'b1, 32'h80FF_0000, 3, 4'hF, 32'h0000_0100, 32'h0,        1'b0, 5'd7,  32'hFFFF_FF80, 1'b1, 2'd0};
        vecs[2]  = '{3'd4, 32'h0000_0102, 32'h1234_56AB, 5'd9, 32'h0,        1'b1, 32'h0,        2, 4'h4, 32'h0000_0100, 32'hABAB_ABAB, 1'b1, 5'd0,  32'h0,        1'b0, 2'd0};
        vecs[3]  = '{3'd3, 32'h0000_0006, 32'h0,        5'd3,  32'h0000_0099, 1'b1, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 2'd1};
        vecs[4]  = '{3'd2, 32'h0000_0201, 32'h0,        5'd10, 32'h0,        1'b1, 32'h1234_F0AB, 1, 4'hF, 32'h0000_0200, 32'h0,        1'b0, 5'd10, 32'h0000_00F0, 1'b1, 2'd0};
        vecs[5]  = '{3'd1, 32'h0000_0200, 32'h0,        5'd11, 32'h0,        1'b0, 32'h0000_007F, 1, 4'hF, 32'h0000_0200, 32'h0,        1'b0, 5'd11, 32'h0000_007F, 1'b0, 2'd0};
        vecs[6]  = '{3'd3, 32'h0000_0300, 32'h0,        5'd12, 32'h0,        1'b1, 32'hDEAD_BEEF, 4, 4'hF, 32'h0000_0300, 32'h0,        1'b0, 5'd12, 32'hDEAD_BEEF, 1'b1, 2'd0};
        vecs[7]  = '{3'd5, 32'h0000_0404, 32'hCAFE_F00D, 5'd1, 32'h0,        1'b1, 32'h0,        1, 4'hF, 32'h0000_0404, 32'hCAFE_F00D, 1'b1, 5'd0,  32'h0,        1'b0, 2'd0};
        vecs[8]  = '{3'd4, 32'h0000_0401, 32'h0000_005A, 5'd2, 32'h0,        1'b1, 32'h0,        1, 4'h2, 32'h0000_0400, 32'h5A5A_5A5A, 1'b1, 5'd0,  32'h0,        1'b0, 2'd0};
        vecs[9]  = '{3'd7, 32'h0000_0000, 32'h0,        5'd13, 32'h0000_0055, 1'b1, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b0, 5'd13, 32'h0000_0055, 1'b1, 2'd0};
        vecs[10] = '{3'd5, 32'h0000_0402, 32'h1,        5'd4,  32'h0,        1'b1, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 2'd1};
        vecs[11] = '{3'd2, 32'h0000_0503, 32'h0,        5'd14, 32'h0,        1'b1, 32'hA500_0000, 2, 4'hF, 32'h0000_0500, 32'h0,        1'b0, 5'd14, 32'h0000_00A5, 1'b1, 2'd0};

        rst           = 1'b1;
        u_if.flush_i  = 1'b0;
        u_if.dack_i   = 1'b0;
        u_if.drdata_i = 32'h0;
        drive_ex(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        check("rst_dreq", 32'(u_if.dreq_o), 32'd0);
        check("rst_stall", 32'(u_if.stall_req_o), 32'd0);
        check("rst_excp", 32'(u_if.excp_o), 32'd0);
        check("rst_excp_code", 32'(u_if.excp_code_o), 32'd0);
        check("rst_waddr", 32'(u_if.waddr_o), 32'd0);
        check("rst_wdata", u_if.wdata_o, 32'd0);
        check("rst_mem_write", 32'(u_if.mem_write_o), 32'd0);
        check("rst_dbe_dwe", 32'({u_if.dbe_o, u_if.dwe_o}), 32'd0);
        check("rst_daddr", u_if.daddr_o, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Instruction held during BUSY is taken only after the transfer completes
        push(5'd20, 32'h1111_2222, 1'b1, 2'd0);
        push(5'd21, 32'h0000_0077, 1'b1, 2'd0);
        drive_ex(1'b1, 3'd3, 32'h0000_0010, 32'h0, 5'd20, 32'h0, 1'b1);
        tick();
        drive_ex(1'b1, 3'd0, 32'h0, 32'h0, 5'd21, 32'h0000_0077, 1'b1);
        tick();
        u_if.dack_i   = 1'b1;
        u_if.drdata_i = 32'h1111_2222;
        tick();
        u_if.dack_i = 1'b0;
        check("hold_stall_after_ack", 32'(u_if.stall_req_o), 32'd0);
        tick();
        drive_ex(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();

        // Bus timeout: TIMEOUT BUSY cycles, then a code-10 exception
        push(5'd0, 32'h0, 1'b0, 2'd2);
        drive_ex(1'b1, 3'd3, 32'h0000_0020, 32'h0, 5'd16, 32'h0, 1'b1);
        tick();
        drive_ex(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        wait_idle(n);
        check("timeout_busy_cycles", n, TO);
        check("timeout_dreq", 32'(u_if.dreq_o), 32'd0);
        tick();

        // Killed transfer that times out raises nothing
        drive_ex(1'b1, 3'd3, 32'h0000_0024, 32'h0, 5'd17, 32'h0, 1'b1);
        tick();
        drive_ex(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        u_if.flush_i = 1'b1;
        tick();
        u_if.flush_i = 1'b0;
        wait_idle(n);
        check("flush_timeout_busy_cycles", n + 1, TO);
        check("flush_timeout_dreq", 32'(u_if.dreq_o), 32'd0);
        tick();

        // Killed load that completes produces a bubble
        drive_ex(1'b1, 3'd1, 32'h0000_0104, 32'h0, 5'd15, 32'h0, 1'b1);
        tick();
        drive_ex(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        u_if.flush_i = 1'b1;
        tick();
        u_if.flush_i = 1'b0;
        check("flush_still_requesting", 32'(u_if.dreq_o), 32'd1);
        u_if.dack_i   = 1'b1;
        u_if.drdata_i = 32'h0000_007F;
        tick();
        u_if.dack_i = 1'b0;
        check("flush_ack_stall", 32'(u_if.stall_req_o), 32'd0);
        tick();

        // Ack in the final (timeout) cycle completes normally
        push(5'd18, 32'h0BEE_F000, 1'b1, 2'd0);
        drive_ex(1'b1, 3'd3, 32'h0000_0030, 32'h0, 5'd18, 32'h0, 1'b1);
        tick();
        drive_ex(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        for (int c = 1; c <= int'(TO); c++) begin
            if (c == int'(TO)) begin
                u_if.dack_i   = 1'b1;
                u_if.drdata_i = 32'h0BEE_F000;
                check("late_ack_still_busy", 32'(u_if.stall_req_o), 32'd1);
            end
            tick();
        end
        u_if.dack_i = 1'b0;
        check("late_ack_stall", 32'(u_if.stall_req_o), 32'd0);
        tick();

        // Reset mid-BUSY abandons the transfer; a stray ack afterwards is ignored
        drive_ex(1'b1, 3'd3, 32'h0000_0040, 32'h0, 5'd19, 32'h0, 1'b1);
        tick();
        drive_ex(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
        check("pre_rst_busy", 32'(u_if.stall_req_o), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_dreq", 32'(u_if.dreq_o), 32'd0);
        check("mid_rst_stall", 32'(u_if.stall_req_o), 32'd0);
        rst           = 1'b0;
        u_if.dack_i   = 1'b1;
        u_if.drdata_i = 32'h1234_5678;
        tick();
        u_if.dack_i = 1'b0;
        check("stray_ack_stall", 32'(u_if.stall_req_o), 32'd0);
        check("stray_ack_dreq", 32'(u_if.dreq_o), 32'd0);
        tick();
        tick();

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_lsu.md
EX_MEM_LSU -- requirements
Module: ex_mem_lsu

Interface
REQ-001 Parameter: TIMEOUT, default 255, meaning the maximum number of BUSY cycles waited for dack_i before aborting.
REQ-002 Port: clk, input, 1, system clock; all state updates on the rising edge.
REQ-003 Port: rst, input, 1; the reset is synchronous, active-high.
REQ-004 Port: ex_valid_i, input, 1, instruction present from the EX stage.
REQ-005 Port: ex_op_i, input, 3, memory op: 000 NONE, 001 LB, 010 LBU, 011 LW, 100 SB, 101 SW; 110/111 treated as NONE.
REQ-006 Port: ex_addr_i, input, 32, effective address.
REQ-007 Port: ex_sdata_i, input, 32, store data.
REQ-008 Port: ex_waddr_i, input, 5, destination register.
REQ-009 Port: ex_wdata_i, input, 32, ALU result for non-load ops.
REQ-010 Port: ex_wreg_i, input, 1, register write request.
REQ-011 Port: flush_i, input, 1, kill the current instruction.
REQ-012 Port: dreq_o, output, 1, data bus request.
REQ-013 Port: dwe_o, output, 1, data bus write.
REQ-014 Port: dbe_o, output, 4, byte enables.
REQ-015 Port: daddr_o, output, 32, word address {addr[31:2],2'b00}.
REQ-016 Port: dwdata_o, output, 32, write data.
REQ-017 Port: drdata_i, input, 32, read data, valid with dack_i.
REQ-018 Port: dack_i, input, 1, bus transfer complete.
REQ-019 Port: stall_req_o, output, 1, hold EX stage.
REQ-020 Port: waddr_o, output, 5, destination register to the Mem stage.
REQ-021 Port: wdata_o, output, 32, write data to the Mem stage.
REQ-022 Port: mem_write_o, output, 1, register write enable to the Mem stage.
REQ-023 Port: excp_o, output, 1, one-cycle exception pulse.
REQ-024 Port: excp_code_o, output, 2, exception code: 01 misaligned, 10 bus timeout.

Function
REQ-025 The block SHALL have two states, IDLE and BUSY; stall_req_o SHALL equal (state==BUSY), combinationally.
REQ-026 IDLE, ex_valid_i=1, flush_i=0, op NONE: the block SHALL register waddr_o/wdata_o/mem_write_o from ex_waddr_i/ex_wdata_i/ex_wreg_i (1-cycle latency).
REQ-027 IDLE, memory op, LW/SW with addr[1:0]!=0: the block SHALL issue no bus request; it SHALL drive excp_o=1 with excp_code_o=01 for one cycle and output a bubble.
REQ-028 IDLE, aligned memory op: the block SHALL latch op/addr/data/waddr/wreg, enter BUSY, and output a bubble.
REQ-029 Bubble: waddr_o=0, wdata_o=0, mem_write_o=0; the same values SHALL be output in IDLE with ex_valid_i=0 or flush_i=1, and in every BUSY cycle without completion.
REQ-030 BUSY: dreq_o=1 with daddr_o/dbe_o/dwe_o/dwdata_o held constant, driven from the latched values; in IDLE dreq_o=0.
REQ-031 SB: dbe_o=4'b0001<<addr[1:0]; dwdata_o=byte replicated ×4; dwe_o=1.
REQ-032 SW: dbe_o=1111; dwdata_o=sdata; dwe_o=1.
REQ-033 Loads: dbe_o=1111, dwe_o=0.
REQ-034 BUSY with dack_i=1: the block SHALL return to IDLE; loads SHALL output wdata_o=extracted lane, waddr_o=latched, mem_write_o=latched wreg; stores SHALL output mem_write_o=0.
REQ-035 Lane extraction: the byte SHALL be drdata_i[8*addr[1:0]+:8], little-endian; LB SHALL sign-extend it, LBU SHALL zero-extend it, LW SHALL use the whole word.
REQ-036 EX inputs SHALL be ignored while BUSY, including on the completing edge; the held instruction SHALL be accepted in the following IDLE cycle.
REQ-037 flush_i=1 in BUSY: the block SHALL continue requesting until ack or timeout, set a kill flag, and output a bubble on completion with no excp_o.
REQ-038 Wait counter: an 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; when the count reaches TIMEOUT-1 without ack, the block SHALL return to IDLE, drop dreq_o, output a bubble, and drive excp_o=1 with code 10, unless killed.
REQ-039 dack_i in the timeout cycle: ack SHALL win, completing normally with no exception.
REQ-040 dack_i while IDLE SHALL be ignored.

Reset
REQ-041 With rst=1 at a clock edge, the block SHALL go to state IDLE and clear the counter and kill flag; all outputs SHALL be 0 (dreq_o=0, stall_req_o=0, excp_o=0, excp_code_o=00).
REQ-042 Reset SHALL take effect mid-BUSY, abandoning the transfer without an exception.

Verification
REQ-043 NONE, waddr=5, wdata=0x1234, wreg=1 -> next cycle waddr_o=5, wdata_o=0x1234, mem_write_o=1, dreq_o=0.
REQ-044 LB at addr 0x103, drdata_i=0x80FF_0000, ack after 3 BUSY cycles -> stall_req_o high for 3 cycles, dbe_o=1111, then wdata_o=0xFFFF_FF80, mem_write_o=1.
REQ-045 SB at addr 0x102, sdata=0xAB -> dbe_o=0100, dwdata_o=0xABABABAB, dwe_o=1; on ack mem_write_o=0.
REQ-046 LW at addr 0x6 -> excp_o=1, code 01, dreq_o never asserted, mem_write_o=0.
REQ-047 LW with no ack, TIMEOUT=255 -> after 255 BUSY cycles dreq_o=0, excp_o=1, code 10; repeat with flush_i=1 during BUSY -> excp_o stays 0 and a bubble is output.
REQ-048 rst=1 asserted during BUSY -> next cycle dreq_o=0, stall_req_o=0, and a late dack_i is ignored.
